// File: rtl/spi_dma_fifo_pkg.sv
// spi_dma_fifo shared definitions.
// Default sizes and the FIFO pointer type.
package spi_dma_fifo_pkg;
  localparam int SPI_FIFO_DEPTH = 8;
  localparam int SPI_DW = 16;
  localparam int SPI_AW = $clog2(SPI_FIFO_DEPTH);
  typedef logic [SPI_AW-1:0] spi_fifo_ptr_t;
endpackage

// File: rtl/spi_sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers.
// A pop frees a slot for a push in the same cycle.
module spi_sync_fifo
  import spi_dma_fifo_pkg::*;
#(
  parameter int DEPTH = SPI_FIFO_DEPTH,
  parameter int DW = SPI_DW
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  logic [DW-1:0]          wdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] cnt,
  output logic [DW-1:0]          head
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [AW:0] wp;
  logic [AW:0] rp;
  logic [DW-1:0] mem [DEPTH];
  logic do_push;
  logic do_pop;

  assign cnt = wp - rp;
  assign empty = (wp == rp);
  assign full = (cnt == FULL_CNT);
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head = empty ? '0 : mem[rp[AW-1:0]];

  // pointer update; flush wins over any push or pop
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wp <= '0;
      rp <= '0;
    end else if (flush) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
    end
  end

  // storage write
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wp[AW-1:0]] <= wdata;
  end
endmodule

// File: rtl/spi_dma_fifo.sv
// Elastic rx/tx buffer between SPI and its DMA engine.
// One-cycle blackout after each SPI pulse covers SPI's level lag.
module spi_dma_fifo
  import spi_dma_fifo_pkg::*;
#(
  parameter int DEPTH = SPI_FIFO_DEPTH,
  parameter int DW = SPI_DW
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   spi_dff,
  input  logic                   flush,
  input  logic                   spi_rxne,
  input  logic [DW-1:0]          spi_rxbuff,
  output logic                   spi_rxreq,
  input  logic                   spi_txe,
  output logic                   spi_txreq,
  output logic [DW-1:0]          spi_txbuff,
  output logic                   dma_rxne,
  output logic [DW-1:0]          dma_rxbuff,
  input  logic                   dma_rxreq,
  output logic                   dma_txe,
  input  logic                   dma_txreq,
  input  logic [DW-1:0]          dma_txbuff,
  output logic [$clog2(DEPTH):0] rx_cnt,
  output logic [$clog2(DEPTH):0] tx_cnt,
  output logic                   rx_udf,
  output logic                   tx_ovf
);
  logic rx_full, rx_empty;
  logic tx_full, tx_empty;
  logic rx_blk, tx_blk;
  logic [DW-1:0] rx_wdata, tx_wdata;

  function automatic logic [DW-1:0] fmt(
    input logic dff,
    input logic [DW-1:0] d
  );
    return dff ? d : {{(DW-8){1'b0}}, d[7:0]};
  endfunction

  assign spi_rxreq = spi_rxne && !rx_full && !rx_blk;
  assign spi_txreq = spi_txe && !tx_empty && !tx_blk;
  assign dma_rxne = !rx_empty;
  assign dma_txe = !tx_full;
  assign rx_wdata = fmt(spi_dff, spi_rxbuff);
  assign tx_wdata = fmt(spi_dff, dma_txbuff);

  spi_sync_fifo #(.DEPTH(DEPTH), .DW(DW)) u_rx (
    .clk   (clk),
    .rstn  (rstn),
    .flush (flush),
    .push  (spi_rxreq),
    .pop   (dma_rxreq),
    .wdata (rx_wdata),
    .full  (rx_full),
    .empty (rx_empty),
    .cnt   (rx_cnt),
    .head  (dma_rxbuff)
  );

  spi_sync_fifo #(.DEPTH(DEPTH), .DW(DW)) u_tx (
    .clk   (clk),
    .rstn  (rstn),
    .flush (flush),
    .push  (dma_txreq),
    .pop   (spi_txreq),
    .wdata (tx_wdata),
    .full  (tx_full),
    .empty (tx_empty),
    .cnt   (tx_cnt),
    .head  (spi_txbuff)
  );

  // blackout: block the SPI side for the cycle after a pulse
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_blk <= 1'b0;
      tx_blk <= 1'b0;
    end else begin
      rx_blk <= spi_rxreq;
      tx_blk <= spi_txreq;
    end
  end

  // sticky error flags; a full push paired with a pop is legal
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_udf <= 1'b0;
      tx_ovf <= 1'b0;
    end else if (flush) begin
      rx_udf <= 1'b0;
      tx_ovf <= 1'b0;
    end else begin
      if (dma_rxreq && rx_empty) rx_udf <= 1'b1;
      if (dma_txreq && tx_full && !spi_txreq) tx_ovf <= 1'b1;
    end
  end
endmodule

// File: tb/tb_spi_dma_fifo.sv
// Scoreboard bench for spi_dma_fifo.
// Directed stimulus; monitor checks data leaving each FIFO.
module tb_spi_dma_fifo;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic spi_dff = 1'b0;
  logic flush = 1'b0;
  logic spi_rxne = 1'b0;
  logic [15:0] spi_rxbuff = '0;
  logic spi_rxreq;
  logic spi_txe = 1'b0;
  logic spi_txreq;
  logic [15:0] spi_txbuff;
  logic dma_rxne;
  logic [15:0] dma_rxbuff;
  logic dma_rxreq = 1'b0;
  logic dma_txe;
  logic dma_txreq = 1'b0;
  logic [15:0] dma_txbuff = '0;
  logic [3:0] rx_cnt, tx_cnt;
  logic rx_udf, tx_ovf;

  int total = 0;
  int bad = 0;
  int rx_pulses = 0;
  int tx_pulses = 0;
  logic prev_rx = 1'b0;
  logic prev_tx = 1'b0;
  logic [15:0] rxq[$];
  logic [15:0] txq[$];

  spi_dma_fifo dut (
    .clk        (clk),
    .rstn       (rstn),
    .spi_dff    (spi_dff),
    .flush      (flush),
    .spi_rxne   (spi_rxne),
    .spi_rxbuff (spi_rxbuff),
    .spi_rxreq  (spi_rxreq),
    .spi_txe    (spi_txe),
    .spi_txreq  (spi_txreq),
    .spi_txbuff (spi_txbuff),
    .dma_rxne   (dma_rxne),
    .dma_rxbuff (dma_rxbuff),
    .dma_rxreq  (dma_rxreq),
    .dma_txe    (dma_txe),
    .dma_txreq  (dma_txreq),
    .dma_txbuff (dma_txbuff),
    .rx_cnt     (rx_cnt),
    .tx_cnt     (tx_cnt),
    .rx_udf     (rx_udf),
    .tx_ovf     (tx_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset();
    chk("rst_rxreq", 32'(spi_rxreq), 0);
    chk("rst_txreq", 32'(spi_txreq), 0);
    chk("rst_txbuff", 32'(spi_txbuff), 0);
    chk("rst_rxne", 32'(dma_rxne), 0);
    chk("rst_rxbuff", 32'(dma_rxbuff), 0);
    chk("rst_txe", 32'(dma_txe), 1);
    chk("rst_rxcnt", 32'(rx_cnt), 0);
    chk("rst_txcnt", 32'(tx_cnt), 0);
    chk("rst_udf", 32'(rx_udf), 0);
    chk("rst_ovf", 32'(tx_ovf), 0);
  endtask

  // monitor: pops expected words as the DUT hands data out
  always @(negedge clk) begin
    if (rstn) begin
      if (spi_rxreq) begin
        rx_pulses++;
        chk("rx_gap", 32'(prev_rx), 0);
      end
      if (spi_txreq) begin
        tx_pulses++;
        chk("tx_gap", 32'(prev_tx), 0);
        if (txq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL tx_extra act=%h exp=none", spi_txbuff);
        end else begin
          chk("tx_data", 32'(spi_txbuff), 32'(txq.pop_front()));
        end
      end
      if (dma_rxreq && dma_rxne) begin
        if (rxq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rx_extra act=%h exp=none", dma_rxbuff);
        end else begin
          chk("rx_data", 32'(dma_rxbuff), 32'(rxq.pop_front()));
        end
      end
      prev_rx = spi_rxreq;
      prev_tx = spi_txreq;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    chk_reset();
    tick();
    tick();
    rstn = 1'b1;

    // RX 8-bit
    tick();
    spi_dff = 1'b0;
    spi_rxbuff = 16'hA5C3;
    spi_rxne = 1'b1;
    rxq.push_back(16'h00C3);
    @(negedge clk);
    chk("rx8_req", 32'(spi_rxreq), 1);
    tick();
    spi_rxne = 1'b0;
    @(negedge clk);
    chk("rx8_rxne", 32'(dma_rxne), 1);
    chk("rx8_cnt", 32'(rx_cnt), 1);
    chk("rx8_head", 32'(dma_rxbuff), 32'h00C3);
    tick();
    dma_rxreq = 1'b1;
    tick();
    dma_rxreq = 1'b0;
    @(negedge clk);
    chk("rx8_cnt0", 32'(rx_cnt), 0);

    // RX fill
    tick();
    rx_pulses = 0;
    spi_dff = 1'b1;
    spi_rxbuff = 16'h1234;
    spi_rxne = 1'b1;
    for (int i = 0; i < 9; i++) rxq.push_back(16'h1234);
    repeat (20) tick();
    @(negedge clk);
    chk("fill_pulses", 32'(rx_pulses), 8);
    chk("fill_cnt", 32'(rx_cnt), 8);
    chk("fill_noreq", 32'(spi_rxreq), 0);
    tick();
    dma_rxreq = 1'b1;
    tick();
    dma_rxreq = 1'b0;
    @(negedge clk);
    chk("fill_cnt7", 32'(rx_cnt), 7);
    chk("fill_req", 32'(spi_rxreq), 1);
    repeat (4) tick();
    @(negedge clk);
    chk("fill_pulses9", 32'(rx_pulses), 9);
    chk("fill_cnt8", 32'(rx_cnt), 8);
    tick();
    spi_rxne = 1'b0;
    dma_rxreq = 1'b1;
    repeat (8) tick();
    dma_rxreq = 1'b0;
    @(negedge clk);
    chk("drain_cnt", 32'(rx_cnt), 0);
    chk("drain_udf", 32'(rx_udf), 0);
    chk("drain_q", 32'(rxq.size()), 0);

    // TX burst with overflow
    spi_txe = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      dma_txreq = 1'b1;
      dma_txbuff = 16'(16'h1111 * (i + 1));
      txq.push_back(dma_txbuff);
    end
    tick();
    dma_txbuff = 16'h9999;
    @(negedge clk);
    chk("burst_txe", 32'(dma_txe), 0);
    chk("burst_cnt", 32'(tx_cnt), 8);
    chk("burst_ovf0", 32'(tx_ovf), 0);
    tick();
    dma_txreq = 1'b0;
    @(negedge clk);
    chk("burst_ovf", 32'(tx_ovf), 1);
    chk("burst_cnt8", 32'(tx_cnt), 8);
    tick();
    tx_pulses = 0;
    spi_txe = 1'b1;
    repeat (20) tick();
    spi_txe = 1'b0;
    @(negedge clk);
    chk("burst_pulses", 32'(tx_pulses), 8);
    chk("burst_cnt0", 32'(tx_cnt), 0);
    chk("burst_q", 32'(txq.size()), 0);

    // underflow and flush
    tick();
    dma_rxreq = 1'b1;
    tick();
    dma_rxreq = 1'b0;
    @(negedge clk);
    chk("udf_set", 32'(rx_udf), 1);
    chk("udf_cnt", 32'(rx_cnt), 0);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    @(negedge clk);
    chk("flush_udf", 32'(rx_udf), 0);
    chk("flush_ovf", 32'(tx_ovf), 0);

    // full with simultaneous push and pop
    for (int i = 0; i < 8; i++) begin
      tick();
      dma_txreq = 1'b1;
      dma_txbuff = 16'(16'hA001 + i);
      txq.push_back(dma_txbuff);
    end
    tick();
    dma_txbuff = 16'hBEEF;
    spi_txe = 1'b1;
    txq.push_back(16'hBEEF);
    @(negedge clk);
    chk("sim_req", 32'(spi_txreq), 1);
    tick();
    dma_txreq = 1'b0;
    spi_txe = 1'b0;
    @(negedge clk);
    chk("sim_cnt", 32'(tx_cnt), 8);
    chk("sim_ovf", 32'(tx_ovf), 0);
    tick();
    tx_pulses = 0;
    spi_txe = 1'b1;
    repeat (20) tick();
    spi_txe = 1'b0;
    @(negedge clk);
    chk("sim_pulses", 32'(tx_pulses), 8);
    chk("sim_cnt0", 32'(tx_cnt), 0);
    chk("sim_q", 32'(txq.size()), 0);

    // TX 8-bit
    tick();
    spi_dff = 1'b0;
    dma_txreq = 1'b1;
    dma_txbuff = 16'hABCD;
    txq.push_back(16'h00CD);
    tick();
    dma_txreq = 1'b0;
    spi_txe = 1'b1;
    @(negedge clk);
    chk("tx8_cnt", 32'(tx_cnt), 1);
    chk("tx8_req", 32'(spi_txreq), 1);
    tick();
    spi_txe = 1'b0;
    @(negedge clk);
    chk("tx8_cnt0", 32'(tx_cnt), 0);

    // reset mid-burst
    tick();
    spi_dff = 1'b1;
    spi_rxbuff = 16'h5555;
    spi_rxne = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rx_cnt == 4'd5) break;
    end
    spi_rxne = 1'b0;
    chk("rst_fill5", 32'(rx_cnt), 5);
    #2;
    rstn = 1'b0;
    #1;
    chk_reset();
    rxq.delete();
    txq.delete();
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("post_rxne", 32'(dma_rxne), 0);
    chk("post_cnt", 32'(rx_cnt), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
